// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M-style multiply/divide unit, one radix-2 step per cycle
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_FIN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic              r_neg;
  logic [XLEN-1:0]   r_b;       // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;      // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_result;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_last;
  logic [XLEN-1:0]   w_fix_result;

  // A new operation may start from IDLE or straight out of FIN; FLUSH always vetoes it.
  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_FIN)) && START && !FLUSH;

  // Signed operand handling: compute on magnitudes and fix the sign at the end.
  assign w_a_signed = (FUNCT3 == 3'b001) | (FUNCT3 == 3'b010) | (FUNCT3[2] & ~FUNCT3[0]);
  assign w_b_signed = (FUNCT3 == 3'b001) | (FUNCT3[2] & ~FUNCT3[0]);
  assign w_a_neg    = w_a_signed & OPERAND1[XLEN-1];
  assign w_b_neg    = w_b_signed & OPERAND2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -OPERAND1 : OPERAND1;
  assign w_b_mag    = w_b_neg ? -OPERAND2 : OPERAND2;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign w_div_zero    = (OPERAND2 == '0);
  assign w_ovf         = FUNCT3[2] & ~FUNCT3[0] &
                         (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) & (OPERAND2 == '1);
  assign w_fast        = FUNCT3[2] & (w_div_zero | w_ovf);
  assign w_fast_result = w_div_zero ? (FUNCT3[1] ? OPERAND1 : '1)
                                    : (FUNCT3[1] ? '0 : OPERAND1);

  // One shift-add multiply step and one restoring shift-subtract divide step.
  assign w_sum   = {1'b0, r_hi} + ({1'b0, r_b} & {(XLEN+1){r_lo[0]}});
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_last  = (r_cnt == CNT_W'(XLEN-1));

  // Sign correction and selection of the requested half/quotient/remainder.
  always_comb begin
    w_fix_result = r_lo;
    case (r_funct3)
      3'b000:                 w_fix_result = r_lo;
      3'b001, 3'b010, 3'b011: w_fix_result = r_neg ? (~r_hi + {{(XLEN-1){1'b0}}, (r_lo == '0)}) : r_hi;
      3'b100, 3'b101:         w_fix_result = r_neg ? -r_lo : r_lo;
      default:                w_fix_result = r_neg ? -r_hi : r_hi;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_state_next = r_state;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_fast ? S_FIN : S_CALC;
      end
      S_CALC: begin
        BUSY = 1'b1;
        if (FLUSH)       w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_FIX;
      end
      S_FIX: begin
        BUSY         = 1'b1;
        w_state_next = FLUSH ? S_IDLE : S_FIN;
      end
      default: begin
        DONE = 1'b1;
        if (w_accept) w_state_next = w_fast ? S_FIN : S_CALC;
        else          w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_funct3 <= FUNCT3;
      r_cnt    <= '0;
      r_neg    <= (FUNCT3 == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);
      r_hi     <= '0;
      if (FUNCT3[2]) begin
        r_b  <= w_b_mag;
        r_lo <= w_a_mag;
      end else begin
        r_b  <= w_a_mag;
        r_lo <= w_b_mag;
      end
      if (w_fast) r_result <= w_fast_result;
    end else if ((r_state == S_CALC) && !FLUSH) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_funct3[2]) begin
        r_hi <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end else if ((r_state == S_FIX) && !FLUSH) begin
      r_result <= w_fix_result;
    end
  end

  assign RESULT = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with an arithmetic reference model
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic            START = 1'b0;
  logic            FLUSH = 1'b0;
  logic [2:0]      FUNCT3 = 3'b000;
  logic [XLEN-1:0] OPERAND1 = '0;
  logic [XLEN-1:0] OPERAND2 = '0;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          c0;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_res = '0;
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = 64'(sa * sb);      return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every DONE pops one expectation and checks result and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1 && DONE === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", DONE, 0);
        end else begin
          e = sb_q.pop_front();
          check({e.tag, "_result"}, RESULT, e.res);
          check({e.tag, "_latency"}, cyc - e.c0 + 1, e.lat);
          last_res = e.res;
        end
      end
    end
  end

  // mode 0: no DONE expected, 1: reference model, 2: given constant.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input logic [31:0] want, input string tag);
    exp_t e;
    FUNCT3 = f; OPERAND1 = a; OPERAND2 = b; START = 1'b1;
    if (mode != 0) begin
      e.res = (mode == 2) ? want : ref_model(f, a, b);
      e.c0  = cyc + 1;
      e.lat = is_fast(f, a, b) ? 1 : XLEN + 2;
      e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    FUNCT3 = 3'($urandom); OPERAND1 = $urandom; OPERAND2 = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int busy_n = 0;
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1)      seen = 1;
      else if (BUSY === 1'b1) busy_n++;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    if (seen) check({tag, "_busy_in_fin"}, BUSY, 0);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] want, input string tag);
    issue(f, a, b, 2, want, tag);
    wait_done(tag, is_fast(f, a, b) ? 0 : XLEN + 1);
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    #1;
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_result", RESULT, 0);

    // First START right at reset release, on the first edge afterwards.
    @(negedge CLK);
    RESET = 1'b1;
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");

    // Back-to-back: MULHU issued in the FIN cycle of MULH.
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, "mulh_min");
    wait_done("mulh_min", XLEN + 1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, "mulhu_max");
    wait_done("mulhu_max", XLEN + 1);
    @(negedge CLK);

    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    run(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
    run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    run(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");

    // START during CALC is ignored (a div-by-zero would otherwise finish at once).
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF1, 1, '0, "mul_ign_start");
    repeat (3) @(negedge CLK);
    FUNCT3 = 3'd5; OPERAND1 = 32'd9; OPERAND2 = 32'd0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done("mul_ign_start", XLEN + 1 - 3);
    @(negedge CLK);

    // FLUSH in FIN: DONE stays, a simultaneous START is rejected.
    issue(3'd5, $urandom, $urandom | 32'h1, 1, '0, "divu_fin_flush");
    wait_done("divu_fin_flush", XLEN + 1);
    FUNCT3 = 3'd5; OPERAND2 = 32'd0; START = 1'b1; FLUSH = 1'b1;
    #1;
    check("fin_flush_done_kept", DONE, 1);
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    @(negedge CLK);
    check("fin_flush_start_rej_busy", BUSY, 0);
    check("fin_flush_start_rej_done", DONE, 0);

    // FLUSH and START together in IDLE: nothing accepted.
    FUNCT3 = 3'd5; OPERAND1 = 32'd3; OPERAND2 = 32'd0; START = 1'b1; FLUSH = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    @(negedge CLK);
    check("idle_flush_busy", BUSY, 0);
    check("idle_flush_done", DONE, 0);

    // FLUSH on the 10th CALC cycle abandons the divide.
    prev = last_res;
    issue(3'd5, $urandom, $urandom | 32'h1, 0, '0, "divu_flush");
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    check("calc_flush_busy", BUSY, 0);
    repeat (40) @(negedge CLK);
    check("calc_flush_result_kept", RESULT, prev);

    // Asynchronous reset on the 5th CALC cycle.
    issue(3'd0, $urandom | 32'h1, $urandom | 32'h1, 0, '0, "mul_reset");
    repeat (5) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("async_rst_busy", BUSY, 0);
    check("async_rst_done", DONE, 0);
    check("async_rst_result", RESULT, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (40) @(negedge CLK);
    check("post_rst_result", RESULT, 0);
    run(3'd0, 32'd3, 32'd4, 32'd12, "mul_3x4");

    // Randomized operations, sometimes back-to-back.
    for (int n = 0; n < 150; n++) begin
      rf = 3'($urandom);
      ra = pick();
      rb = pick();
      issue(rf, ra, rb, 1, '0, $sformatf("rnd%0d_f%0d", n, rf));
      wait_done($sformatf("rnd%0d", n), is_fast(rf, ra, rb) ? 0 : XLEN + 1);
      if ($urandom_range(0, 1) == 0) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, sets operand and result width in bits; legal values 8..64, even.
REQ-002 Port CLK  input  1  the only clock; all state changes on its rising edge.
REQ-003 Port RESET  input  1  asynchronous, active-low reset.
REQ-004 Port START  input  1  request to begin an operation; sampled only while idle.
REQ-005 Port FUNCT3  input  3  RV32M operation code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port OPERAND1  input  XLEN  rs1 value (multiplicand / dividend).
REQ-007 Port OPERAND2  input  XLEN  rs2 value (multiplier / divisor).
REQ-008 Port FLUSH  input  1  abort request from the pipeline, e.g. a taken branch or jump.
REQ-009 Port BUSY  output  1  high while an accepted operation is still in progress.
REQ-010 Port DONE  output  1  one-cycle pulse marking RESULT valid.
REQ-011 Port RESULT  output  XLEN  operation result, registered.

Function
REQ-012 The FSM SHALL have four states: IDLE, CALC, FIX and FIN.
REQ-013 In IDLE, START=1 with FLUSH=0 SHALL latch FUNCT3, OPERAND1 and OPERAND2; operands SHALL NOT be re-read after that edge.
REQ-014 An accepted normal operation SHALL go IDLE->CALC, and the iteration counter SHALL be cleared.
REQ-015 CALC SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) for exactly XLEN cycles, then go to FIX.
REQ-016 FIX SHALL apply the sign correction for signed variants and register RESULT, then go to FIN.
REQ-017 FIN SHALL assert DONE for exactly one cycle and return to IDLE on the next edge.
REQ-018 Latency: DONE SHALL go high XLEN+2 edges after the edge that sampled START.
REQ-019 BUSY SHALL equal (state==CALC or state==FIX) and SHALL be low during the FIN cycle.
REQ-020 A START in the FIN cycle SHALL be accepted, giving back-to-back operation with no bubble.
REQ-021 START while in CALC or FIX SHALL be ignored; it SHALL have no effect on state, latched operands or RESULT.
REQ-022 Multiply SHALL form the full 2*XLEN-bit product. MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits for signed*signed, signed*unsigned and unsigned*unsigned operands.
REQ-023 Divide SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 Divisor==0 SHALL take a fast path IDLE->FIN with DONE high 1 edge after the START edge. The quotient SHALL be all-ones; the remainder SHALL equal OPERAND1. This applies to both signed and unsigned variants.
REQ-025 Signed overflow (DIV/REM, OPERAND1 = -2^(XLEN-1), OPERAND2 = -1) SHALL take the same fast path. The quotient SHALL equal OPERAND1; the remainder SHALL be 0.
REQ-026 FLUSH=1 in CALC or FIX SHALL force IDLE on the next edge. DONE SHALL NOT pulse and RESULT SHALL keep its previous value.
REQ-027 FLUSH=1 in FIN SHALL suppress nothing: DONE still pulses. A START in that same cycle SHALL be rejected.
REQ-028 FLUSH and START high together in IDLE: FLUSH SHALL win and no operation SHALL be accepted.
REQ-029 RESULT SHALL hold its value from DONE until the next FIX or fast-path completion.
REQ-030 The counter SHALL be ceil(log2(XLEN))+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-031 RESET=0 SHALL immediately, without waiting for CLK, force state to IDLE and set BUSY=0, DONE=0, RESULT=0, counter=0 and all latched operands to 0.
REQ-032 Reset asserted mid-operation SHALL abandon that operation; no DONE SHALL follow the reset release.
REQ-033 The first START SHALL be accepted on the first rising edge after RESET returns high.

Verification (XLEN=32)
REQ-034 MUL, OPERAND1=7, OPERAND2=0xFFFFFFFD -> DONE 34 edges later, RESULT=0xFFFFFFEB; BUSY high for 33 cycles.
REQ-035 MULH, 0x80000000 * 0x80000000 -> RESULT=0x40000000. Then MULHU, 0xFFFFFFFF * 0xFFFFFFFF, issued in the FIN cycle -> RESULT=0xFFFFFFFE, with no idle cycle between the two operations.
REQ-036 DIV, 0xFFFFFFF9 / 2 -> RESULT=0xFFFFFFFD; REM on the same operands -> RESULT=0xFFFFFFFF; DIVU 100 / 7 -> RESULT=14.
REQ-037 DIVU 5/0 -> RESULT=0xFFFFFFFF and REMU 5/0 -> RESULT=5, each with DONE 1 edge after START. DIV 0x80000000 / 0xFFFFFFFF -> RESULT=0x80000000 and REM on the same operands -> RESULT=0, both via the fast path.
REQ-038 Start DIVU; FLUSH=1 on the 10th CALC cycle -> BUSY low next cycle, no DONE within 40 cycles, RESULT unchanged.
REQ-039 Start MUL; pull RESET low on the 5th CALC cycle -> BUSY, DONE and RESULT go to 0 before the next edge. After release, START MUL 3*4 -> RESULT=12.
